// File: rtl/frame_pixel_server.sv
// frame_pixel_server
//   Memory-side responder for the grayscale front end. On i_start it streams
//   one IMG_ROW x IMG_COL frame in raster order. Frame words are fetched from
//   the SDRAM read port into a prefetch FIFO; one 30-bit RGB pixel is handed
//   out per cycle that i_read_request is high (1-cycle latency).
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_start             1-cycle pulse, starts a frame when idle
//   o_ready             high while streaming (consumer may request)
//   i_read_request      consume one pixel this cycle
//   o_red/green/blue    presented pixel (10b each), held when not valid
//   o_pixel_valid       a new pixel is presented this cycle
//   o_row, o_col        raster position of the presented pixel
//   o_frame_done        1-cycle pulse after the last pixel was presented
//   o_underflow         sticky: request seen while the FIFO was empty
//   o_sdram_read/addr   read command, held until i_sdram_ack
//   i_sdram_ack         command accepted this cycle
//   i_sdram_rdata       {r,g,b} read data, in command order
//   i_sdram_rvalid      read data valid
module frame_pixel_server #(
    parameter int IMG_COL    = 640,
    parameter int IMG_ROW    = 480,
    parameter int FIFO_DEPTH = 16,
    parameter int FILL_LEVEL = 8,
    parameter int BASE_ADDR  = 0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    output logic        o_ready,
    input  logic        i_read_request,
    output logic [9:0]  o_red,
    output logic [9:0]  o_green,
    output logic [9:0]  o_blue,
    output logic        o_pixel_valid,
    output logic [8:0]  o_row,
    output logic [9:0]  o_col,
    output logic        o_frame_done,
    output logic        o_underflow,
    output logic        o_sdram_read,
    output logic [22:0] o_sdram_addr,
    input  logic        i_sdram_ack,
    input  logic [29:0] i_sdram_rdata,
    input  logic        i_sdram_rvalid
);

    localparam int NPIX = IMG_ROW * IMG_COL;
    localparam int CW   = $clog2(NPIX + 1);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int OW   = $clog2(FIFO_DEPTH + 1);

    localparam logic [CW-1:0] NPIX_C   = CW'(NPIX);
    localparam logic [OW:0]   DEPTH_C  = (OW + 1)'(FIFO_DEPTH);
    localparam logic [OW-1:0] FILL_C   = OW'(FILL_LEVEL);
    localparam logic [22:0]   BASE_C   = 23'(BASE_ADDR);
    localparam logic [9:0]    LAST_COL = 10'(IMG_COL - 1);

    // Elaboration-time configuration guard.
    generate
        if ((longint'(BASE_ADDR) + longint'(NPIX) - 1) > 64'h7F_FFFF) begin : g_bad_addr
            $fatal(1, "frame_pixel_server: frame does not fit in 23-bit address space");
        end
        if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
            FILL_LEVEL > FIFO_DEPTH || FILL_LEVEL < 1) begin : g_bad_fifo
            $fatal(1, "frame_pixel_server: bad FIFO_DEPTH / FILL_LEVEL");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_STREAM, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [22:0]    addr_q, addr_d;
    logic [CW-1:0]  issued_q, issued_d;   // commands accepted this frame
    logic [CW-1:0]  popped_q, popped_d;   // pixels popped this frame
    logic [OW-1:0]  outs_q, outs_d;       // reads accepted but not returned
    logic [OW-1:0]  cnt_q, cnt_d;         // FIFO occupancy
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [8:0]     nrow_q, nrow_d;       // position of the next pixel to pop
    logic [9:0]     ncol_q, ncol_d;
    logic [8:0]     row_q, row_d;
    logic [9:0]     col_q, col_d;
    logic [29:0]    pix_q, pix_d;
    logic           pvalid_q, pvalid_d;
    logic           ready_q, ready_d;
    logic           fdone_q, fdone_d;
    logic           uflow_q, uflow_d;

    logic [29:0]    fifo_mem_q [FIFO_DEPTH];

    logic fetching, sdram_read, ack, push, want, pop;

    always_comb begin
        fetching   = (state_q == S_FILL) || (state_q == S_STREAM);
        // Credit check counts in-flight reads so a returning word always has a slot.
        sdram_read = fetching && (issued_q < NPIX_C) &&
                     (({1'b0, cnt_q} + {1'b0, outs_q}) < DEPTH_C);
        ack        = sdram_read && i_sdram_ack;
        // Returns with nothing in flight (stale data after a reset) are dropped.
        push       = fetching && i_sdram_rvalid && (outs_q != '0);
        // Requests past the end of the frame are not real demand.
        want       = (state_q == S_STREAM) && i_read_request && (popped_q < NPIX_C);
        pop        = want && (cnt_q != '0);

        state_d  = state_q;
        addr_d   = addr_q;
        issued_d = issued_q;
        popped_d = popped_q;
        outs_d   = outs_q;
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        nrow_d   = nrow_q;
        ncol_d   = ncol_q;
        row_d    = row_q;
        col_d    = col_q;
        pix_d    = pix_q;
        pvalid_d = 1'b0;
        uflow_d  = uflow_q;

        if (ack) begin
            addr_d   = addr_q + 23'd1;
            issued_d = issued_q + CW'(1);
        end

        case ({ack, push})
            2'b10:   outs_d = outs_q + OW'(1);
            2'b01:   outs_d = outs_q - OW'(1);
            default: outs_d = outs_q;
        endcase

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + OW'(1);
            2'b01:   cnt_d = cnt_q - OW'(1);
            default: cnt_d = cnt_q;
        endcase

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);

        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            pix_d    = fifo_mem_q[rd_ptr_q];
            pvalid_d = 1'b1;
            row_d    = nrow_q;
            col_d    = ncol_q;
            popped_d = popped_q + CW'(1);
            if (ncol_q == LAST_COL) begin
                ncol_d = '0;
                nrow_d = nrow_q + 9'd1;
            end else begin
                ncol_d = ncol_q + 10'd1;
            end
        end

        if (want && (cnt_q == '0)) uflow_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d  = S_FILL;
                    addr_d   = BASE_C;
                    issued_d = '0;
                    popped_d = '0;
                    outs_d   = '0;
                    cnt_d    = '0;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    nrow_d   = '0;
                    ncol_d   = '0;
                end
            end
            S_FILL: begin
                // Small frames may never reach FILL_LEVEL; stream once all data is in.
                if (cnt_q >= FILL_C || (issued_q == NPIX_C && outs_q == '0))
                    state_d = S_STREAM;
            end
            S_STREAM: begin
                // Last pixel is on the outputs this cycle.
                if (pvalid_q && popped_q == NPIX_C) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_STREAM);
        fdone_d = (state_d == S_DONE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            issued_q <= '0;
            popped_q <= '0;
            outs_q   <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            nrow_q   <= '0;
            ncol_q   <= '0;
            row_q    <= '0;
            col_q    <= '0;
            pix_q    <= '0;
            pvalid_q <= 1'b0;
            ready_q  <= 1'b0;
            fdone_q  <= 1'b0;
            uflow_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            issued_q <= issued_d;
            popped_q <= popped_d;
            outs_q   <= outs_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            nrow_q   <= nrow_d;
            ncol_q   <= ncol_d;
            row_q    <= row_d;
            col_q    <= col_d;
            pix_q    <= pix_d;
            pvalid_q <= pvalid_d;
            ready_q  <= ready_d;
            fdone_q  <= fdone_d;
            uflow_q  <= uflow_d;
        end
    end

    // FIFO storage needs no reset; occupancy/pointers define validity.
    always_ff @(posedge i_clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= i_sdram_rdata;
    end

    // o_sdram_read is decoded from flops only, so it is stable for the whole cycle.
    assign o_sdram_read  = sdram_read;
    assign o_sdram_addr  = addr_q;
    assign o_ready       = ready_q;
    assign o_red         = pix_q[29:20];
    assign o_green       = pix_q[19:10];
    assign o_blue        = pix_q[9:0];
    assign o_pixel_valid = pvalid_q;
    assign o_row         = row_q;
    assign o_col         = col_q;
    assign o_frame_done  = fdone_q;
    assign o_underflow   = uflow_q;

endmodule
